// File: rtl/fifo_queue_flags_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_queue_flags_if
// Brief    : Handshake / status bundle between a producer-consumer pair and
//            the flagged FIFO. The master modport is the user side. The slave
//            modport is the FIFO side.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_queue_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  enq;
    logic                  deq;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output enq, deq, din,
        input  dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  enq, deq, din,
        output dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_queue_flags.sv
`default_nettype none
// ============================================================================
// Module   : fifo_queue_flags
// Brief    : Single-clock FIFO with occupancy count, almost-full/almost-empty
//            thresholds and one-cycle overflow/underflow pulses. When the FIFO
//            is full, an enq and a deq in the same cycle are both accepted.
//            Define FIFO_FWFT_EN to select first-word-fall-through read data.
//            With the macro undefined, read data is registered with a
//            one-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_queue_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_queue_flags_if.slave q
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_af      = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   c_ae      = (AW+1)'(AE_LEVEL);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [AW:0]           w_count_next;

    // Accept decisions. A read frees a slot, so a full FIFO still takes a
    // write when a read is accepted in the same cycle.
    always_comb begin
        w_rd_ok      = q.deq & ~r_empty;
        w_wr_ok      = q.enq & (~r_full | w_rd_ok);
        w_count_next = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
    end

    // Storage array. It is not reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[r_wr_ptr] <= q.din;
        end
    end

    // Pointers, occupancy, and flags. The flags are derived from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count        <= w_count_next;
            r_full         <= (w_count_next == c_depth);
            r_empty        <= (w_count_next == '0);
            r_almost_full  <= (w_count_next >= c_af);
            r_almost_empty <= (w_count_next <= c_ae);
            r_overflow     <= q.enq & ~w_wr_ok;
            r_underflow    <= q.deq & ~w_rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head word is shown combinationally from the registered state.
    // An empty FIFO shows zero.
    assign q.dout = r_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_dout;

    // Registered read. The head word is captured on an accepted read, and the
    // value is held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_ok) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    assign q.dout = r_dout;
`endif

    assign q.full         = r_full;
    assign q.empty        = r_empty;
    assign q.almost_full  = r_almost_full;
    assign q.almost_empty = r_almost_empty;
    assign q.count        = r_count;
    assign q.overflow     = r_overflow;
    assign q.underflow    = r_underflow;

endmodule
`default_nettype wire
